check_data_scanner: RTL and testbench
=====================================

Name: check_data_scanner

Overview:
- Reader side of the per-stage debug select interface: drives check_addr, samples the returned check_data, and builds a snapshot of every pipeline segment (IF, ID, EX, MEM, WB, HZD).
- Streams the snapshot to the debug unit over a valid/ready handshake.
- Keeps the snapshot in a buffer with a random-access read port, so segment words can be re-read without rescanning.
- Sits between the CPU's segment-select mux and the PDU/debug host logic.

Parameters:
- NUM_SEG, 6, number of segments scanned; addresses 0..NUM_SEG-1; max 8.
- SETTLE, 1, wait cycles after each check_addr change before sampling; 0 is legal.
- DATA_W, 32, width of check_data and of buffer entries.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to begin a scan; ignored unless in IDLE.
- check_addr  output  3  segment select driven to the segment mux.
- check_data  input  DATA_W  selected segment word, combinational return from the mux.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last word is accepted.
- out_valid  output  1  stream word valid.
- out_ready  input  1  consumer ready.
- out_addr  output  3  segment index of the current stream word.
- out_data  output  DATA_W  current stream word.
- rd_sel  input  3  snapshot read index.
- rd_data  output  DATA_W  combinational buffer[rd_sel]; 0 when rd_sel >= NUM_SEG.

Behaviour:
- Reset values, registered outputs: check_addr=0, busy=0, done=0, out_valid=0, out_addr=0, out_data=0, FSM=IDLE. Buffer contents after reset are 0.
- FSM states: IDLE, SETTLE_WAIT, CAPTURE, EMIT, FINISH.
- IDLE:
  - start=1 -> check_addr=0, settle counter=SETTLE, next state SETTLE_WAIT. With SETTLE=0, go directly to CAPTURE.
- SETTLE_WAIT: decrement the counter each cycle; at 0 -> CAPTURE.
- CAPTURE:
  - buffer[check_addr] <= check_data.
  - If check_addr == NUM_SEG-1 -> EMIT with index 0.
  - Else check_addr+1, reload the counter, return to SETTLE_WAIT (or stay in CAPTURE when SETTLE=0).
- Scan timing: each address is held for SETTLE+1 cycles and sampled on its last cycle. Total scan = NUM_SEG*(SETTLE+1) cycles after the start cycle (12 with defaults).
- check_addr holds its last scanned value (NUM_SEG-1) until the next start or reset.
- EMIT:
  - out_valid=1; out_addr=index; out_data=buffer[index].
  - Advance only on out_valid && out_ready.
  - While out_ready=0, out_addr and out_data are held stable and out_valid stays high.
  - On the handshake of index NUM_SEG-1 -> FINISH, out_valid=0 on the next cycle.
  - out_ready held high gives one word per cycle, no bubbles.
- FINISH: done=1 for exactly one cycle, busy still 1, then -> IDLE. start during FINISH is ignored.
- start while busy: ignored, no queuing.
- rd_data: reflects the buffer at all times. During a scan, entries update as they are captured (partial snapshot); a complete snapshot is guaranteed from the FINISH cycle onward.
- rst mid-scan or mid-emit: everything returns to reset values on the next edge, buffer cleared, no done pulse.
- Counter widths: settle counter = clog2(SETTLE+1) bits, minimum 1; index = 3 bits. No wrap-around is reachable because NUM_SEG <= 8.

Decomposition:
- Shared debug package holds:
  - segment index constants SEG_IF=0, SEG_ID=1, SEG_EX=2, SEG_MEM=3, SEG_WB=4, SEG_HZD=5;
  - the FSM state encoding;
  - CHECK_ADDR_W=3.
- One natural sub-module, snapshot_buffer:
  - NUM_SEG x DATA_W registers with synchronous clear on rst;
  - one write port (capture) and two combinational read ports (emit index, rd_sel).

Test Plan:
- Pipe the scanner through a model segment mux returning 32'h1000_0000+addr, SETTLE=1, out_ready=1, pulse start: check_addr steps 0..5, each held 2 cycles. The stream then emits (0,10000000)..(5,10000005) on 6 consecutive cycles, and done pulses exactly once, the cycle after the last handshake.
- Backpressure: drop out_ready for 3 cycles while out_addr=2 -> out_valid, out_addr=2 and out_data=10000002 stay stable. The stream resumes with 3 on the cycle after ready returns, and no word is lost or duplicated.
- Pulse start again mid-scan and during FINISH -> no restart, check_addr sequence unchanged, exactly one done.
- Assert rst while check_addr=3 -> next cycle busy=0, check_addr=0, out_valid=0, rd_data=0 for every rd_sel, no done pulse. A subsequent start performs a full correct scan.
- After done, sweep rd_sel 0..7 -> rd_data = 10000000..10000005, then 0, 0. Change the model's data and confirm rd_data is unchanged until the next scan.
- SETTLE=0 build -> check_addr advances every cycle, scan completes in 6 cycles, captured values are correct.

Source files
------------

// File: rtl/check_data_scanner_pkg.sv
// Shared debug definitions for the segment scanner:
// segment indices, select width and scanner FSM encoding.
package check_data_scanner_pkg;

    localparam int CHECK_ADDR_W = 3;

    localparam logic [CHECK_ADDR_W-1:0] SEG_IF  = 3'd0;
    localparam logic [CHECK_ADDR_W-1:0] SEG_ID  = 3'd1;
    localparam logic [CHECK_ADDR_W-1:0] SEG_EX  = 3'd2;
    localparam logic [CHECK_ADDR_W-1:0] SEG_MEM = 3'd3;
    localparam logic [CHECK_ADDR_W-1:0] SEG_WB  = 3'd4;
    localparam logic [CHECK_ADDR_W-1:0] SEG_HZD = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE_WAIT,
        ST_CAPTURE,
        ST_EMIT,
        ST_FINISH
    } scan_state_e;

endpackage

// File: rtl/check_data_scanner_buffer.sv
// Snapshot storage: one capture write port, two combinational
// read ports (stream index and random-access select).
module snapshot_buffer
    import check_data_scanner_pkg::*;
#(
    parameter int NUM_SEG = 6,
    parameter int DATA_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_i,
    input  logic [CHECK_ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]       wr_data_i,
    input  logic [CHECK_ADDR_W-1:0] emit_idx_i,
    output logic [DATA_W-1:0]       emit_data_o,
    input  logic [CHECK_ADDR_W-1:0] rd_sel_i,
    output logic [DATA_W-1:0]       rd_data_o
);

    localparam logic [CHECK_ADDR_W-1:0] LAST = CHECK_ADDR_W'(NUM_SEG - 1);

    logic [DATA_W-1:0] mem_q [NUM_SEG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (wr_addr_i <= LAST)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Indices past the last segment read as zero.
    assign emit_data_o = (emit_idx_i <= LAST) ? mem_q[emit_idx_i] : '0;
    assign rd_data_o   = (rd_sel_i <= LAST) ? mem_q[rd_sel_i] : '0;

endmodule

// File: rtl/check_data_scanner.sv
// Debug segment scanner: walks check_addr over every pipeline segment,
// snapshots check_data, then streams the snapshot over valid/ready.
module check_data_scanner
    import check_data_scanner_pkg::*;
#(
    parameter int NUM_SEG = 6,
    parameter int SETTLE  = 1,
    parameter int DATA_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [CHECK_ADDR_W-1:0] check_addr,
    input  logic [DATA_W-1:0]       check_data,
    output logic                    busy,
    output logic                    done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CHECK_ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0]       out_data,
    input  logic [CHECK_ADDR_W-1:0] rd_sel,
    output logic [DATA_W-1:0]       rd_data
);

    localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
    localparam logic [CHECK_ADDR_W-1:0] LAST = CHECK_ADDR_W'(NUM_SEG - 1);

    scan_state_e             state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CHECK_ADDR_W-1:0] addr_q;
    logic [CHECK_ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0]       out_data_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    valid_q;

    logic                    cap_we;
    logic [CHECK_ADDR_W-1:0] emit_idx_d;
    logic [DATA_W-1:0]       emit_rd;
    logic [DATA_W-1:0]       emit_data_d;

    assign cap_we     = (state_q == ST_CAPTURE);
    assign emit_idx_d = cap_we ? '0 : out_addr_q + 3'd1;
    // Bypass the word being captured this cycle (single-segment scans).
    assign emit_data_d = (cap_we && (addr_q == emit_idx_d)) ? check_data : emit_rd;

    snapshot_buffer #(
        .NUM_SEG (NUM_SEG),
        .DATA_W  (DATA_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .we_i        (cap_we),
        .wr_addr_i   (addr_q),
        .wr_data_i   (check_data),
        .emit_idx_i  (emit_idx_d),
        .emit_data_o (emit_rd),
        .rd_sel_i    (rd_sel),
        .rd_data_o   (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q  <= '0;
                        cnt_q   <= SETTLE_LD;
                        busy_q  <= 1'b1;
                        state_q <= (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE_WAIT;
                    end
                end
                ST_SETTLE_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (addr_q == LAST) begin
                        state_q    <= ST_EMIT;
                        valid_q    <= 1'b1;
                        out_addr_q <= '0;
                        out_data_q <= emit_data_d;
                    end else begin
                        addr_q <= addr_q + 3'd1;
                        cnt_q  <= SETTLE_LD;
                        if (SETTLE != 0) begin
                            state_q <= ST_SETTLE_WAIT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (valid_q && out_ready) begin
                        if (out_addr_q == LAST) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_FINISH;
                        end else begin
                            out_addr_q <= emit_idx_d;
                            out_data_q <= emit_data_d;
                        end
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign check_addr = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign out_valid  = valid_q;
    assign out_addr   = out_addr_q;
    assign out_data   = out_data_q;

endmodule

// File: tb/tb_check_data_scanner.sv
// Bench for check_data_scanner: SETTLE=1 and SETTLE=0 instances driven
// by a model segment mux, checked against a snapshot/stream reference.
module tb_check_data_scanner;

    localparam int N  = 6;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, out_ready;
    logic [2:0]    check_addr, out_addr, rd_sel;
    logic [DW-1:0] check_data, out_data, rd_data;
    logic          busy, done, out_valid;
    logic [DW-1:0] base;

    logic          rst0, start0, ready0;
    logic [2:0]    ca0, oa0, rs0;
    logic [DW-1:0] cd0, od0, rd0;
    logic          busy0, done0, ov0;
    logic [DW-1:0] base0;

    int vectors    = 0;
    int miscompares = 0;

    // Model segment mux: each segment returns base + index.
    assign check_data = base + 32'(check_addr);
    assign cd0        = base0 + 32'(ca0);

    check_data_scanner #(.NUM_SEG(N), .SETTLE(1), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .check_addr(check_addr), .check_data(check_data),
        .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .rd_sel(rd_sel), .rd_data(rd_data)
    );

    check_data_scanner #(.NUM_SEG(N), .SETTLE(0), .DATA_W(DW)) dut0 (
        .clk(clk), .rst(rst0), .start(start0),
        .check_addr(ca0), .check_data(cd0),
        .busy(busy0), .done(done0),
        .out_valid(ov0), .out_ready(ready0),
        .out_addr(oa0), .out_data(od0),
        .rd_sel(rs0), .rd_data(rd0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected snapshot word for segment s given the mux base.
    function automatic logic [31:0] snap(input logic [31:0] b, input int s);
        return (s < N) ? b + 32'(s) : 32'h0;
    endfunction

    task automatic sweep(input string tag, input logic [31:0] b, input bit cleared);
        for (int s = 0; s < 8; s++) begin
            rd_sel = 3'(s);
            #1;
            chk(tag, rd_data, cleared ? 32'h0 : snap(b, s));
        end
    endtask

    // mode 0: ready held high, 1: 3-cycle stall at index 2, 2: random ready
    task automatic run_scan(input int mode, input bit poke);
        int idx, cyc, stalls;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int a = 0; a < N; a++) begin
            for (int s = 0; s < 2; s++) begin
                chk("scan_addr", check_addr, a);
                chk("scan_busy", busy, 1);
                chk("scan_valid", out_valid, 0);
                start = poke && (a == 2) && (s == 0);
                step();
            end
        end
        start = 1'b0;
        idx = 0; cyc = 0; stalls = 0;
        while (idx < N && cyc < 100) begin
            if (mode == 1 && idx == 2 && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else if (mode == 2) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            chk("emit_valid", out_valid, 1);
            chk("emit_addr", out_addr, idx);
            chk("emit_data", out_data, snap(base, idx));
            chk("emit_done", done, 0);
            step();
            if (out_ready) idx++;
            cyc++;
        end
        chk("emit_complete", idx, N);
        if (mode == 0) chk("emit_cycles", cyc, N);
        if (mode == 1) chk("emit_cycles_stall", cyc, N + 3);
        out_ready = 1'b1;
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 1);
        chk("fin_valid", out_valid, 0);
        start = poke;
        step();
        start = 1'b0;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        step();
        chk("idle_restart", busy, 0);
        chk("idle_done2", done, 0);
        chk("idle_addr_hold", check_addr, N - 1);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; rd_sel = '0;
        rst0 = 1'b1; start0 = 1'b0; ready0 = 1'b1; rs0 = '0;
        base = 32'h1000_0000;
        base0 = $urandom;
        step();
        step();
        rst = 1'b0; rst0 = 1'b0;

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_addr", check_addr, 0);
        chk("rst_oaddr", out_addr, 0);
        chk("rst_odata", out_data, 0);
        sweep("rst_rd", base, 1'b1);

        run_scan(0, 1'b0);
        sweep("snap_rd", base, 1'b0);
        base = $urandom;
        sweep("snap_hold", 32'h1000_0000, 1'b0);
        base = 32'h1000_0000;

        run_scan(1, 1'b0);
        run_scan(0, 1'b1);

        // Reset in the middle of a scan.
        base = $urandom;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (check_addr != 3'd3 && cyc < 50) begin
            step();
            cyc++;
        end
        chk("reach_addr3", check_addr, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", check_addr, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_done", done, 0);
        sweep("mid_rst_rd", base, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst_nodone", done, 0);
            chk("mid_rst_idle", busy, 0);
        end

        for (int r = 0; r < 4; r++) begin
            base = $urandom;
            run_scan(2, r[0]);
            sweep("rand_rd", base, 1'b0);
        end

        // SETTLE=0 instance: one address per cycle.
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int a = 0; a < N; a++) begin
            chk("s0_addr", ca0, a);
            chk("s0_busy", busy0, 1);
            step();
        end
        for (int i = 0; i < N; i++) begin
            chk("s0_valid", ov0, 1);
            chk("s0_oaddr", oa0, i);
            chk("s0_odata", od0, snap(base0, i));
            step();
        end
        chk("s0_done", done0, 1);
        chk("s0_valid_low", ov0, 0);
        for (int s = 0; s < 8; s++) begin
            rs0 = 3'(s);
            #1;
            chk("s0_rd", rd0, snap(base0, s));
        end
        step();
        chk("s0_idle", busy0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
